// File: rtl/tt_um_jleugeri_ttt_router.sv
// Sequential TTT event router: scans snapshotted start/stop events per source and
// accumulates signed, saturating good/bad token deltas through a programmable fan-out table.
module tt_um_jleugeri_ttt_router #(
    parameter int NUM_PROCESSORS  = 10,
    parameter int FANOUT          = 3,
    parameter int NEW_TOKENS_BITS = 4,
    parameter int WEIGHT_BITS     = 3,
    localparam int IDX_W  = $clog2(NUM_PROCESSORS),
    localparam int SLOT_W = (FANOUT > 1) ? $clog2(FANOUT) : 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [2*NUM_PROCESSORS-1:0]           tstartstop,
    input  logic                                  go_in,
    output logic                                  busy_out,
    output logic                                  done_out,
    input  logic                                  cfg_we,
    input  logic [IDX_W-1:0]                      cfg_src,
    input  logic [SLOT_W-1:0]                     cfg_slot,
    input  logic                                  cfg_valid,
    input  logic [IDX_W-1:0]                      cfg_tgt,
    input  logic [WEIGHT_BITS-1:0]                cfg_w_good,
    input  logic [WEIGHT_BITS-1:0]                cfg_w_bad,
    output logic [NUM_PROCESSORS*NEW_TOKENS_BITS-1:0] new_good_tokens,
    output logic [NUM_PROCESSORS*NEW_TOKENS_BITS-1:0] new_bad_tokens
);

    localparam int B     = NEW_TOKENS_BITS;
    localparam int W     = WEIGHT_BITS;
    localparam int SUM_W = ((B > W + 1) ? B : W + 1) + 1;
    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((2 ** (B - 1)) - 1);
    localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-(2 ** (B - 1)));

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_ROUTE, S_DONE} state_t;

    state_t                        r_state, w_state_next;
    logic [2*NUM_PROCESSORS-1:0]   r_events;
    logic [IDX_W-1:0]              r_src;
    logic [SLOT_W-1:0]             r_slot;

    logic                          r_cfg_valid [NUM_PROCESSORS][FANOUT];
    logic [IDX_W-1:0]              r_cfg_tgt   [NUM_PROCESSORS][FANOUT];
    logic [W-1:0]                  r_cfg_wg    [NUM_PROCESSORS][FANOUT];
    logic [W-1:0]                  r_cfg_wb    [NUM_PROCESSORS][FANOUT];

    logic w_start, w_stop, w_active, w_neg, w_last_src, w_last_slot, w_cfg_ok, w_load;
    logic                 w_ent_valid;
    logic [IDX_W-1:0]     w_ent_tgt;
    logic signed [W:0]    w_wg_ext, w_wb_ext, w_term_good, w_term_bad;

    // Add at full width, then clamp; the clamped value is what later terms build on.
    function automatic logic signed [B-1:0] sat_add(input logic signed [B-1:0] a,
                                                    input logic signed [W:0]   t);
        logic signed [SUM_W-1:0] s;
        s = {{(SUM_W - B){a[B-1]}}, a} + {{(SUM_W - W - 1){t[W]}}, t};
        if (s > SAT_MAX)      return SAT_MAX[B-1:0];
        else if (s < SAT_MIN) return SAT_MIN[B-1:0];
        else                  return s[B-1:0];
    endfunction

    assign w_start     = r_events[{r_src, 1'b0}];
    assign w_stop      = r_events[{r_src, 1'b1}];
    assign w_active    = w_start ^ w_stop;
    assign w_neg       = w_stop & ~w_start;
    assign w_last_src  = (r_src == IDX_W'(NUM_PROCESSORS - 1));
    assign w_last_slot = (r_slot == SLOT_W'(FANOUT - 1));

    assign w_ent_valid = r_cfg_valid[r_src][r_slot];
    assign w_ent_tgt   = r_cfg_tgt[r_src][r_slot];
    assign w_wg_ext    = {r_cfg_wg[r_src][r_slot][W-1], r_cfg_wg[r_src][r_slot]};
    assign w_wb_ext    = {r_cfg_wb[r_src][r_slot][W-1], r_cfg_wb[r_src][r_slot]};
    assign w_term_good = w_neg ? -w_wg_ext : w_wg_ext;
    assign w_term_bad  = w_neg ? -w_wb_ext : w_wb_ext;

    assign w_cfg_ok = (r_state == S_IDLE) && cfg_we
                   && ({1'b0, cfg_src}  < (IDX_W + 1)'(NUM_PROCESSORS))
                   && ({1'b0, cfg_slot} < (SLOT_W + 1)'(FANOUT));

    assign busy_out = (r_state != S_IDLE);
    assign done_out = (r_state == S_DONE);
    assign w_load   = (w_state_next == S_DONE);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (go_in) w_state_next = S_SCAN;
            S_SCAN: begin
                if (w_active)        w_state_next = S_ROUTE;
                else if (w_last_src) w_state_next = S_DONE;
            end
            S_ROUTE: if (w_last_slot) w_state_next = w_last_src ? S_DONE : S_SCAN;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_events <= '0;
            r_src    <= '0;
            r_slot   <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: if (go_in) begin
                    r_events <= tstartstop;
                    r_src    <= '0;
                end
                S_SCAN: begin
                    if (w_active)         r_slot <= '0;
                    else if (!w_last_src) r_src  <= r_src + 1'b1;
                end
                S_ROUTE: begin
                    if (!w_last_slot)     r_slot <= r_slot + 1'b1;
                    else if (!w_last_src) r_src  <= r_src + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_PROCESSORS; s++) begin
                for (int f = 0; f < FANOUT; f++) begin
                    r_cfg_valid[s][f] <= 1'b0;
                    r_cfg_tgt[s][f]   <= '0;
                    r_cfg_wg[s][f]    <= '0;
                    r_cfg_wb[s][f]    <= '0;
                end
            end
        end else if (w_cfg_ok) begin
            r_cfg_valid[cfg_src][cfg_slot] <= cfg_valid;
            r_cfg_tgt[cfg_src][cfg_slot]   <= cfg_tgt;
            r_cfg_wg[cfg_src][cfg_slot]    <= cfg_w_good;
            r_cfg_wb[cfg_src][cfg_slot]    <= cfg_w_bad;
        end
    end

    // Out-of-range targets never match any gi, so they drop out naturally.
    for (genvar gi = 0; gi < NUM_PROCESSORS; gi++) begin : g_tgt
        logic                 w_hit;
        logic signed [B-1:0]  r_acc_good, r_acc_bad, w_good_next, w_bad_next;
        logic [B-1:0]         r_out_good, r_out_bad;

        assign w_hit       = (r_state == S_ROUTE) && w_ent_valid && (w_ent_tgt == IDX_W'(gi));
        assign w_good_next = w_hit ? sat_add(r_acc_good, w_term_good) : r_acc_good;
        assign w_bad_next  = w_hit ? sat_add(r_acc_bad,  w_term_bad)  : r_acc_bad;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_acc_good <= '0;
                r_acc_bad  <= '0;
                r_out_good <= '0;
                r_out_bad  <= '0;
            end else begin
                if (r_state == S_IDLE && go_in) begin
                    r_acc_good <= '0;
                    r_acc_bad  <= '0;
                end else begin
                    r_acc_good <= w_good_next;
                    r_acc_bad  <= w_bad_next;
                end
                if (w_load) begin
                    r_out_good <= w_good_next;
                    r_out_bad  <= w_bad_next;
                end
            end
        end

        assign new_good_tokens[gi*B +: B] = r_out_good;
        assign new_bad_tokens[gi*B +: B]  = r_out_bad;
    end

endmodule

// File: tb/tb_tt_um_jleugeri_ttt_router.sv
// Directed bench for the TTT router at N=4, F=2, B=4, W=3: table of config writes
// and scans with hand-computed results, plus mid-scan disturbance and reset sequences.
module tb_tt_um_jleugeri_ttt_router;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  tstartstop;
    logic        go_in;
    logic        busy_out, done_out;
    logic        cfg_we;
    logic [1:0]  cfg_src;
    logic        cfg_slot;
    logic        cfg_valid;
    logic [1:0]  cfg_tgt;
    logic [2:0]  cfg_w_good, cfg_w_bad;
    logic [15:0] new_good_tokens, new_bad_tokens;

    int n_tests = 0;
    int n_fail  = 0;

    tt_um_jleugeri_ttt_router #(
        .NUM_PROCESSORS(4), .FANOUT(2), .NEW_TOKENS_BITS(4), .WEIGHT_BITS(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tstartstop(tstartstop), .go_in(go_in),
        .busy_out(busy_out), .done_out(done_out), .cfg_we(cfg_we),
        .cfg_src(cfg_src), .cfg_slot(cfg_slot), .cfg_valid(cfg_valid),
        .cfg_tgt(cfg_tgt), .cfg_w_good(cfg_w_good), .cfg_w_bad(cfg_w_bad),
        .new_good_tokens(new_good_tokens), .new_bad_tokens(new_bad_tokens)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        do_go;
        logic [1:0]  src;
        logic        slot;
        logic        valid;
        logic [1:0]  tgt;
        logic [2:0]  wg;
        logic [2:0]  wb;
        logic [7:0]  tss;
        logic [15:0] eg;
        logic [15:0] eb;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    task automatic cfg_write(input logic [1:0] src, input logic slot, input logic valid,
                             input logic [1:0] tgt, input logic [2:0] wg, input logic [2:0] wb);
        @(negedge clk);
        cfg_we = 1'b1; cfg_src = src; cfg_slot = slot; cfg_valid = valid;
        cfg_tgt = tgt; cfg_w_good = wg; cfg_w_bad = wb;
        @(negedge clk);
        cfg_we = 1'b0;
        $display("[TB] cfg src=%0d slot=%0d valid=%0d tgt=%0d g=%0d b=%0d",
                 src, slot, valid, tgt, $signed(wg), $signed(wb));
    endtask

    // mode 0: plain scan; 1: go/cfg/tstartstop disturbed in cycle 3; 2: reset in cycle 3.
    task automatic run_scan(input logic [7:0] tss, input logic [15:0] eg, input logic [15:0] eb,
                            input int lat, input int mode, input string nm);
        int   cyc;
        logic found;
        @(negedge clk);
        tstartstop = tss;
        go_in      = 1'b1;
        @(negedge clk);
        go_in = 1'b0;
        cyc   = 1;
        check({nm, "_busy"}, 32'(busy_out), 32'd1);
        found = 1'b0;
        while (!found && cyc <= 60) begin
            if (mode == 1 && cyc == 3) begin
                go_in = 1'b1; cfg_we = 1'b1; cfg_src = 2'd3; cfg_slot = 1'b0;
                cfg_valid = 1'b1; cfg_tgt = 2'd0; cfg_w_good = 3'd3; cfg_w_bad = 3'd3;
                tstartstop = 8'h00;
            end
            if (mode == 1 && cyc == 4) begin
                go_in  = 1'b0;
                cfg_we = 1'b0;
            end
            if (mode == 2 && cyc == 3) begin
                rst_n = 1'b0;
                #1;
                check({nm, "_rst_busy"}, 32'(busy_out), 32'd0);
                check({nm, "_rst_done"}, 32'(done_out), 32'd0);
                check({nm, "_rst_good"}, 32'(new_good_tokens), 32'd0);
                check({nm, "_rst_bad"},  32'(new_bad_tokens),  32'd0);
                @(negedge clk);
                rst_n = 1'b1;
                $display("[TB] scan %s: reset asserted in cycle 3", nm);
                return;
            end
            if (done_out === 1'b1) found = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!found) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL %s_timeout: no done_out within 60 cycles, expected cycle %0d", nm, lat);
            return;
        end
        check({nm, "_lat"},  32'(cyc), 32'(lat));
        check({nm, "_good"}, 32'(new_good_tokens), 32'(eg));
        check({nm, "_bad"},  32'(new_bad_tokens),  32'(eb));
        $display("[TB] scan %s: tss=%02h done@%0d good=%04h bad=%04h", nm, tss, cyc,
                 new_good_tokens, new_bad_tokens);
        @(negedge clk);
        check({nm, "_pulse"}, 32'(done_out), 32'd0);
        check({nm, "_idle"},  32'(busy_out), 32'd0);
    endtask

    initial begin
        // Reset with random inputs present.
        rst_n      = 1'b0;
        tstartstop = 8'($urandom);
        go_in      = 1'b1;
        cfg_we     = 1'b1;
        cfg_src    = 2'($urandom);
        cfg_slot   = 1'($urandom);
        cfg_valid  = 1'b1;
        cfg_tgt    = 2'($urandom);
        cfg_w_good = 3'($urandom);
        cfg_w_bad  = 3'($urandom);
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy_out), 32'd0);
        check("reset_done", 32'(done_out), 32'd0);
        check("reset_good", 32'(new_good_tokens), 32'd0);
        check("reset_bad",  32'(new_bad_tokens),  32'd0);
        $display("[TB] reset: busy=%0d done=%0d good=%04h bad=%04h",
                 busy_out, done_out, new_good_tokens, new_bad_tokens);
        tstartstop = 8'h00; go_in = 1'b0; cfg_we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        //               go    src   slot  vld   tgt   wg      wb      tss     eg        eb        lat
        vecs.push_back('{1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 3'b000, 3'b000, 8'h00, 16'h0000, 16'h0000, 5});
        vecs.push_back('{1'b0, 2'd1, 1'b0, 1'b1, 2'd2, 3'b011, 3'b111, 8'h00, 16'h0000, 16'h0000, 0});
        vecs.push_back('{1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 3'b000, 3'b000, 8'h04, 16'h0300, 16'h0F00, 7});
        vecs.push_back('{1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 3'b000, 3'b000, 8'h08, 16'h0D00, 16'h0100, 7});
        vecs.push_back('{1'b0, 2'd0, 1'b0, 1'b1, 2'd0, 3'b011, 3'b000, 8'h00, 16'h0000, 16'h0000, 0});
        vecs.push_back('{1'b0, 2'd1, 1'b0, 1'b1, 2'd0, 3'b011, 3'b000, 8'h00, 16'h0000, 16'h0000, 0});
        vecs.push_back('{1'b0, 2'd3, 1'b0, 1'b1, 2'd0, 3'b011, 3'b000, 8'h00, 16'h0000, 16'h0000, 0});
        vecs.push_back('{1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 3'b000, 3'b000, 8'h45, 16'h0007, 16'h0000, 11});
        vecs.push_back('{1'b0, 2'd0, 1'b0, 1'b1, 2'd0, 3'b100, 3'b000, 8'h00, 16'h0000, 16'h0000, 0});
        vecs.push_back('{1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 3'b000, 3'b000, 8'h02, 16'h0004, 16'h0000, 7});
        // Sticky saturation: good 3,6,7(clamp),3 ; bad -4,-8,-8,-8(clamp from -9).
        vecs.push_back('{1'b0, 2'd0, 1'b0, 1'b1, 2'd0, 3'b011, 3'b100, 8'h00, 16'h0000, 16'h0000, 0});
        vecs.push_back('{1'b0, 2'd0, 1'b1, 1'b1, 2'd0, 3'b011, 3'b100, 8'h00, 16'h0000, 16'h0000, 0});
        vecs.push_back('{1'b0, 2'd3, 1'b0, 1'b1, 2'd0, 3'b100, 3'b111, 8'h00, 16'h0000, 16'h0000, 0});
        vecs.push_back('{1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 3'b000, 3'b000, 8'h45, 16'h0003, 16'h0008, 11});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 1'b0, 2'd1, 3'b011, 3'b011, 8'h00, 16'h0000, 16'h0000, 0});
        vecs.push_back('{1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 3'b000, 3'b000, 8'hFF, 16'h0000, 16'h0000, 5});

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].do_go)
                run_scan(vecs[i].tss, vecs[i].eg, vecs[i].eb, vecs[i].lat, 0, $sformatf("vec%0d", i));
            else
                cfg_write(vecs[i].src, vecs[i].slot, vecs[i].valid, vecs[i].tgt, vecs[i].wg, vecs[i].wb);
        end

        run_scan(8'h45, 16'h0003, 16'h0008, 11, 1, "disturbed");
        run_scan(8'h45, 16'h0003, 16'h0008, 11, 0, "after_disturb");
        run_scan(8'h45, 16'h0003, 16'h0008, 11, 2, "mid_reset");
        run_scan(8'h45, 16'h0000, 16'h0000, 11, 0, "after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tt_um_jleugeri_ttt_router.md
Name: tt_um_jleugeri_ttt_router

Overview:
- Sequential event router for the TTT processor network.
- On each `go_in`, snapshots all processors' start/stop event bits and scans sources one at a time, with a signed sign per source.
- For each active source, walks a configurable fan-out table and accumulates signed good/bad token deltas into per-target saturating counters.
- Publishes the counters as `new_good_tokens`/`new_bad_tokens` when the scan completes. Generalises the fixed mux/demux pair to parametrised processor count, fan-out depth and weight width, with runtime-programmable connectivity.

Parameters:
- `NUM_PROCESSORS`, 10, number of source/target processors (N ≥ 2).
- `FANOUT`, 3, fan-out slots per source (F ≥ 1).
- `NEW_TOKENS_BITS`, 4, signed width B of each per-target token count.
- `WEIGHT_BITS`, 3, signed width W of each connection weight.
- Derived: `IDX_W` = `$clog2(NUM_PROCESSORS)`, `SLOT_W` = max(1, `$clog2(FANOUT)`).

Ports:
- `clk`  in  1  clock, all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `tstartstop`  in  2N  event bits; bit 2i = start of processor i, bit 2i+1 = stop.
- `go_in`  in  1  start scan (sampled in IDLE only).
- `busy_out`  out  1  high in any state other than IDLE.
- `done_out`  out  1  one-cycle pulse, high only in DONE.
- `cfg_we`  in  1  config write strobe (IDLE only).
- `cfg_src`  in  IDX_W  source index written.
- `cfg_slot`  in  SLOT_W  fan-out slot written.
- `cfg_valid`  in  1  entry enable.
- `cfg_tgt`  in  IDX_W  target index.
- `cfg_w_good`  in  W  signed good weight.
- `cfg_w_bad`  in  W  signed bad weight.
- `new_good_tokens`  out  N*B  signed per-target good count; target j at bits [j*B +: B].
- `new_bad_tokens`  out  N*B  signed per-target bad count; same packing.

Behaviour:
- **Reset** (async, `rst_n`=0):
  - State IDLE; `busy_out`=0, `done_out`=0.
  - All output counts 0; accumulators 0.
  - All config entries `valid`=0. Reset mid-scan aborts immediately, with the same values.
- **Config:**
  - `cfg_we`=1 in IDLE writes entry [`cfg_src`][`cfg_slot`] at the clock edge.
  - Writes when busy, or with `cfg_src` ≥ N or `cfg_slot` ≥ F, are ignored.
  - Write and `go_in` in the same IDLE cycle: the write commits, and the scan uses the updated table.
- **State machine:** IDLE, SCAN, ROUTE, DONE.
  - IDLE: on `go_in`=1, snapshot `tstartstop`, clear accumulators, set src=0, go to SCAN. Live `tstartstop` changes after the snapshot have no effect.
  - SCAN: compute sign = start − stop from the snapshot (+1, −1, or 0; both bits set gives 0).
    - sign=0: if src=N−1 go to DONE, else src++ and stay in SCAN.
    - sign≠0: slot=0, go to ROUTE.
  - ROUTE: one slot per cycle.
    - If the entry is valid and its target < N: `acc_good[tgt]` += sign·`w_good` and `acc_bad[tgt]` += sign·`w_bad`.
    - Invalid entry, or target ≥ N: no update.
    - After slot F−1: if src=N−1 go to DONE, else src++ and go to SCAN.
  - Output load: output registers load from the accumulators on the edge entering DONE, and hold until the next scan's DONE.
  - DONE: `done_out`=1 for exactly one cycle, then IDLE.
- **Latency:**
  - Count the cycle after the `go_in` edge as cycle 1. DONE occurs in cycle N + F·A + 1, where A = number of sources with sign≠0.
  - Minimum interval between `go_in` acceptances is N + F·A + 2 cycles.
- **Arithmetic:**
  - sign·weight is computed in W+1 bits, so negating −2^(W−1) is exact.
  - The sum is formed at full width, then clamped to [−2^(B−1), 2^(B−1)−1].
  - Saturation is sticky per addition: later opposite-sign terms add to the clamped value.
- **Ignored inputs:** `go_in` while busy is ignored (not queued).
- **Simultaneous targets:** multiple slots or sources hitting the same target in one scan accumulate in scan order: src ascending, slot ascending.

Test Plan (N=4, F=2, B=4, W=3):
1. **Reset:** assert `rst_n`=0 with random inputs → all outputs 0, `busy_out`=0, `done_out`=0; after release, `go_in` with all-zero `tstartstop` → `done_out` in cycle 5, all counts 0.
2. **Start event:** write src1 slot0 {valid, tgt=2, g=+3, b=−1}, `tstartstop`=8'b0000_0100, `go_in` → `done_out` in cycle 7, `new_good_tokens`[2]=4'h3, `new_bad_tokens`[2]=4'hF, all others 0.
3. **Stop event:** same config, `tstartstop`=8'b0000_1000 → good[2]=4'hD (−3), bad[2]=4'h1.
4. **Saturation and negation:**
   - Sources 0, 1, 3 slot0 {tgt0, g=+3}, all start → good[0]=4'h7 (clamped from 9).
   - Then src0 slot0 g=−4 with stop only → good[0]=4'h4.
5. **Null events:** both start and stop set on every source, plus invalid entries → no accumulation; `done_out` in cycle 5; outputs from the previous scan are replaced by 0.
6. **Robustness:**
   - `go_in` and `cfg_we` pulsed mid-scan → ignored; result matches the undisturbed scan.
   - `rst_n` low in cycle 3 of a scan → immediate IDLE, outputs 0, config cleared.
   - The next scan with the old stimulus → all counts 0.
